// File: rtl/ivl_uvm_arb_pkg.sv
// rtl/ivl_uvm_arb_pkg.sv - shared types and default parameters for the write-bus arbiter
package ivl_uvm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    WAIT_ACK = 2'd2
  } arb_state_e;

  localparam int DEF_N_REQ          = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/ivl_uvm_rr_pick.sv
// rtl/ivl_uvm_rr_pick.sv - combinational round-robin picker, searches upward from ptr+1
module ivl_uvm_rr_pick
  import ivl_uvm_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // First set request after the pointer, wrapping modulo N_REQ; the pointer itself is checked last
  always_comb begin
    int idx;
    valid = 1'b0;
    id    = '0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ivl_uvm_bus_write_arb.sv
// rtl/ivl_uvm_bus_write_arb.sv - round-robin write-bus arbiter; optional watchdog under IVL_UVM_ARB_TIMEOUT_EN
module ivl_uvm_bus_write_arb
  import ivl_uvm_arb_pkg::*;
#(
  parameter  int N_REQ          = DEF_N_REQ,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int ID_W           = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             write_ack,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  grant_id,
  output logic             write,
  output logic             bus_gnt,
  output logic             ack_err,
  output logic             timeout
);

  arb_state_e      state;
  logic [ID_W-1:0] ptr;
  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic            ack;
  logic            expire;

  // X or Z on the slave ack must never end a transaction
  assign ack = (write_ack === 1'b1);

  ivl_uvm_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .id    (pick_id)
  );

`ifdef IVL_UVM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;

  // Watchdog counts cycles spent owning the bus; restarts with every new grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == IDLE) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  // Expiry fires on the edge at which the count would reach TIMEOUT_CYCLES
  assign expire  = (state != IDLE) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  // Watchdog absent: constant 0, parameter kept in the expression so it is still referenced
  assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Transaction sequencer: grant, one-cycle start strobe, hold until ack (or watchdog)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      grant_id  <= ID_W'(N_REQ - 1);
      ptr       <= ID_W'(N_REQ - 1);
      write     <= 1'b0;
      bus_gnt   <= 1'b0;
      ack_err   <= 1'b0;
`ifdef IVL_UVM_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      write     <= 1'b0;
      ack_err   <= 1'b0;
`ifdef IVL_UVM_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ack) begin
            ack_err <= 1'b1;
          end
          if (pick_valid) begin
            gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
            grant_id <= pick_id;
            ptr      <= pick_id;
            write    <= 1'b1;
            bus_gnt  <= 1'b1;
            state    <= START;
          end
        end
        START, WAIT_ACK: begin
          if (ack) begin
            gnt     <= '0;
            bus_gnt <= 1'b0;
            state   <= IDLE;
          end else if (expire) begin
            gnt       <= '0;
            bus_gnt   <= 1'b0;
            state     <= IDLE;
`ifdef IVL_UVM_ARB_TIMEOUT_EN
            timeout_q <= 1'b1;
`endif
          end else begin
            state <= WAIT_ACK;
          end
        end
        default: begin
          gnt     <= '0;
          bus_gnt <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
